router_tx_port: RTL
===================

# router_tx_port

Output-side drain engine for one router port. Reads packet words from the port's 32-bit first-word-fall-through output FIFO using its ready/pop/dout interface. Parses each packet's header length, then presents words on the outgoing link with a valid/ack handshake and start/end-of-packet markers. Sits between the port FIFO and the link serializer, and sustains one word per clock when neither side stalls.

## Interface
- WIDTH, 32, data word width; header length field is always bits [7:0]
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- tx_en  in  1  permits starting a new packet; a packet already started always completes
- fifo_ready  in  1  FIFO holds at least one word (not empty)
- fifo_dout  in  WIDTH  FIFO head word, valid whenever fifo_ready=1
- fifo_pop  out  1  combinational; consumes the FIFO head word this cycle
- tx_valid  out  1  tx_data/tx_sop/tx_eop hold a word for the link
- tx_data  out  WIDTH  registered word
- tx_sop  out  1  word is a packet header
- tx_eop  out  1  word is the last word of the packet
- tx_ack  in  1  link accepts the word on this edge when tx_valid=1
- busy  out  1  registered; 1 from header load until the eop word transfers
- pkt_count  out  16  packets completed since reset; wraps at 65535 to 0

## Operation
- Packet format: header word with payload length L = bits[7:0] (0..255), followed by L payload words. Upper header bits pass through untouched.
- Holding register: tx_valid/tx_data/tx_sop/tx_eop form a one-entry output stage.
- Transfer: tx_valid && tx_ack at a rising edge.
- Load condition: load = fifo_ready && (!tx_valid || tx_ack) && (state==PAYLOAD || tx_en) && reset_n.
  - fifo_pop = load, combinational.
  - On load, fifo_dout is captured into tx_data.
- State machine with states IDLE and PAYLOAD, plus rem[7:0]:
  - IDLE load (header): tx_sop<=1, tx_eop<=(L==0), rem<=L. Next state is PAYLOAD if L!=0, else stay IDLE.
  - PAYLOAD load: tx_sop<=0, tx_eop<=(rem==1), rem<=rem-1. Return to IDLE when rem==1.
- Transfer without load: tx_valid<=0, and sop/eop are cleared.
- No transfer: all holding fields are stable, and data must not change while tx_valid=1 && tx_ack=0.
- Underrun: fifo_ready=0 mid-packet.
  - tx_valid drops after the pending word transfers.
  - State stays PAYLOAD, and rem is preserved.
  - Bubbles are legal; there is no timeout.
- tx_en low: blocks only IDLE loads. Deasserting it mid-packet has no effect until eop.
- busy: set on header load, cleared on eop transfer. If an eop transfer and a new header load happen in the same cycle, busy stays 1.
- pkt_count increments on every eop transfer (16-bit, modulo 2^16).

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, rem=0, tx_valid=0, tx_data=0, tx_sop=0, tx_eop=0, busy=0, pkt_count=0.
- fifo_pop is forced to 0 while reset_n=0, so the FIFO is never drained during reset.
- Reset mid-packet: the partial packet is abandoned, and the remaining FIFO words of it are treated as a new header afterward. The upstream FIFO is reset in the same cycle.
- Latency: FIFO word present with link idle → tx_valid one cycle later.
- Throughput: 1 word/cycle with tx_ack held high and fifo_ready high. Back-to-back packets have no idle cycle between eop and the next sop.
- Length-0 packet: a single word with tx_sop=tx_eop=1.
- A word loaded in cycle n is presented from cycle n+1 until the edge of its transfer.

## Test plan
- Length-0 header 0x0000_AB00, tx_en=1, tx_ack=1 → one tx_valid cycle with sop=eop=1 and data 0x0000_AB00; pkt_count=1; busy is high for 1 cycle.
- Two back-to-back packets (L=3, then L=1), ack held high → 6 consecutive valid cycles; sop on words 0 and 4, eop on words 3 and 5; fifo_pop high 6 cycles; pkt_count=2.
- L=2 packet with tx_ack low for 4 cycles on the first payload word → tx_data stable across the stall, no fifo_pop during the stall, no word lost or duplicated.
- FIFO empties after word 1 of an L=3 packet for 5 cycles, with tx_en dropped meanwhile → tx_valid gap, then payload resumes with eop on the 3rd payload word; the next header is not started until tx_en=1.
- reset_n low for 1 cycle mid-payload of an L=255 packet → next cycle all outputs are 0, busy=0, pkt_count=0; fifo_pop is 0 during the reset cycle.
- 65536 length-0 packets → pkt_count wraps to 0; a 65537th packet gives 1.

Source files
------------

// File: rtl/router_tx_port_if.sv
// FIFO-side and link-side signal bundle for one router transmit port.
// master is the drain engine; slave is the FIFO/link environment around it.
interface router_tx_port_if #(
  parameter int WIDTH = 32
);
  logic             fifo_ready;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_pop;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_sop;
  logic             tx_eop;
  logic             tx_ack;

  modport master (
    input  fifo_ready, fifo_dout, tx_ack,
    output fifo_pop, tx_valid, tx_data, tx_sop, tx_eop
  );

  modport slave (
    output fifo_ready, fifo_dout, tx_ack,
    input  fifo_pop, tx_valid, tx_data, tx_sop, tx_eop
  );
endinterface

// File: rtl/router_tx_port.sv
// Router output-port drain engine: pulls packets from a FWFT FIFO, parses the
// header length and streams words to the link through a one-entry output stage.
module router_tx_port #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tx_en,
  router_tx_port_if.master      bus,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic             vld_p1, vld_d;
  logic [WIDTH-1:0] data_p1, data_d;
  logic             sop_p1, sop_d;
  logic             eop_p1, eop_d;
  logic             busy_q, busy_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             load, xfer;
  logic [7:0]       hdr_len;

  assign hdr_len = bus.fifo_dout[7:0];
  assign xfer    = vld_p1 && bus.tx_ack;
  // Gating on reset_n keeps the FIFO untouched while the port is held in reset.
  assign load    = bus.fifo_ready && (!vld_p1 || bus.tx_ack) &&
                   (state_q == PAYLOAD || tx_en) && reset_n;
  assign bus.fifo_pop = load;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vld_d   = vld_p1;
    data_d  = data_p1;
    sop_d   = sop_p1;
    eop_d   = eop_p1;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    if (xfer && eop_p1) begin
      busy_d = 1'b0;
      cnt_d  = cnt_q + 16'd1;
    end

    if (load) begin
      vld_d  = 1'b1;
      data_d = bus.fifo_dout;
      if (state_q == IDLE) begin
        sop_d   = 1'b1;
        eop_d   = (hdr_len == 8'd0);
        rem_d   = hdr_len;
        state_d = (hdr_len != 8'd0) ? PAYLOAD : IDLE;
        busy_d  = 1'b1;
      end else begin
        sop_d   = 1'b0;
        eop_d   = (rem_q == 8'd1);
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? IDLE : PAYLOAD;
      end
    end else if (xfer) begin
      vld_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
  end

  // Output stage p1: registered holding entry presented to the link
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_p1  <= vld_d;
      data_p1 <= data_d;
      sop_p1  <= sop_d;
      eop_p1  <= eop_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx_valid = vld_p1;
  assign bus.tx_data  = data_p1;
  assign bus.tx_sop   = sop_p1;
  assign bus.tx_eop   = eop_p1;
  assign busy         = busy_q;
  assign pkt_count    = cnt_q;

endmodule
